// File: rtl/if_id_reg_pkg.sv
// -----------------------------------------------------------------------------
// if_id_reg_pkg
// Shared processor definitions for the IF/ID stage and the decoder:
//   fetch_state_t : IF/ID fetch FSM state (S_OP = expect opcode,
//                   S_IMM = expect immediate byte)
//   TWO_BYTE_OPS  : opcode high nibbles that carry an immediate byte
//                   (LDM, LDD, STD)
//   NOP           : opcode byte that decode treats as no-operation
// -----------------------------------------------------------------------------
package if_id_reg_pkg;

    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } fetch_state_t;

    localparam int unsigned NUM_TWO_BYTE_OPS = 3;

    localparam logic [3:0] OP_LDM = 4'hC;
    localparam logic [3:0] OP_LDD = 4'hD;
    localparam logic [3:0] OP_STD = 4'hE;

    localparam logic [3:0] TWO_BYTE_OPS [NUM_TWO_BYTE_OPS] = '{OP_LDM, OP_LDD, OP_STD};

    localparam logic [7:0] NOP = 8'h00;

endpackage

// File: rtl/opcode_len_decode.sv
// -----------------------------------------------------------------------------
// opcode_len_decode
// Combinational instruction-length classifier, shared with the hazard unit.
// Ports:
//   opcode      in  [3:0]  high nibble of the opcode byte
//   is_two_byte out        1 when the opcode is followed by an immediate byte
// -----------------------------------------------------------------------------
module opcode_len_decode
    import if_id_reg_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_two_byte
);

    always_comb begin
        is_two_byte = 1'b0;
        for (int unsigned i = 0; i < NUM_TWO_BYTE_OPS; i++) begin
            if (opcode == TWO_BYTE_OPS[i]) begin
                is_two_byte = 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register for a variable-length (1 or 2 byte) instruction set.
// A two-byte instruction is assembled over two fetch cycles: the opcode is
// latched first (valid_D=0, fetch_imm=1), then the immediate completes it.
// Ports:
//   clk           in       pipeline clock, rising edge
//   reset         in       asynchronous, active-low
//   stall_D       in       hold all state and outputs
//   flush_D       in       discard contents, insert NOP (wins over stall_D)
//   instr_in      in  [7:0] byte fetched at pc_in
//   pc_in         in  [7:0] fetch address
//   pc_plus_1_in  in  [7:0] pc_in + 1 (wrapped upstream)
//   in_port       in  [7:0] external input port sample
//   instr_D       out [7:0] opcode byte (8'h00 = NOP)
//   imm_D         out [7:0] immediate byte, 0 for one-byte instructions
//   pc_D          out [7:0] opcode address
//   pc_plus_1_D   out [7:0] address after the whole instruction
//   in_port_D     out [7:0] in_port registered with the opcode
//   valid_D       out       instr_D/imm_D form a complete instruction
//   fetch_imm     out       registered: 1 while waiting for an immediate
// -----------------------------------------------------------------------------
module if_id_reg
    import if_id_reg_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       stall_D,
    input  logic       flush_D,
    input  logic [7:0] instr_in,
    input  logic [7:0] pc_in,
    input  logic [7:0] pc_plus_1_in,
    input  logic [7:0] in_port,
    output logic [7:0] instr_D,
    output logic [7:0] imm_D,
    output logic [7:0] pc_D,
    output logic [7:0] pc_plus_1_D,
    output logic [7:0] in_port_D,
    output logic       valid_D,
    output logic       fetch_imm
);

    fetch_state_t r_state;
    logic [7:0]   r_instr;
    logic [7:0]   r_imm;
    logic [7:0]   r_pc;
    logic [7:0]   r_pc_plus_1;
    logic [7:0]   r_in_port;
    logic         r_valid;
    logic         w_is_two_byte;

    opcode_len_decode u_len_decode (
        .opcode      (instr_in[7:4]),
        .is_two_byte (w_is_two_byte)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_OP;
            r_instr     <= NOP;
            r_imm       <= '0;
            r_pc        <= '0;
            r_pc_plus_1 <= '0;
            r_in_port   <= '0;
            r_valid     <= 1'b0;
        end else if (flush_D) begin
            r_state     <= S_OP;
            r_instr     <= NOP;
            r_imm       <= '0;
            r_pc        <= '0;
            r_pc_plus_1 <= '0;
            r_in_port   <= '0;
            r_valid     <= 1'b0;
        end else if (!stall_D) begin
            unique case (r_state)
                S_OP: begin
                    r_instr     <= instr_in;
                    r_imm       <= '0;
                    r_pc        <= pc_in;
                    r_pc_plus_1 <= pc_plus_1_in;
                    r_in_port   <= in_port;
                    // A two-byte opcode is held as a bubble until its
                    // immediate arrives.
                    r_valid     <= !w_is_two_byte;
                    r_state     <= w_is_two_byte ? S_IMM : S_OP;
                end
                S_IMM: begin
                    // Immediate fetch address + 1 = opcode address + 2.
                    r_imm       <= instr_in;
                    r_pc_plus_1 <= pc_plus_1_in;
                    r_valid     <= 1'b1;
                    r_state     <= S_OP;
                end
                default: r_state <= S_OP;
            endcase
        end
    end

    assign instr_D     = r_instr;
    assign imm_D       = r_imm;
    assign pc_D        = r_pc;
    assign pc_plus_1_D = r_pc_plus_1;
    assign in_port_D   = r_in_port;
    assign valid_D     = r_valid;
    assign fetch_imm   = (r_state == S_IMM);

endmodule

// File: doc/if_id_reg.md
IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low; clock clk.
REQ-003 stall_D  input  1  from hazard unit; hold all state and outputs this cycle.
REQ-004 flush_D  input  1  from hazard unit; discard fetched content and insert a NOP.
REQ-005 instr_in  input  8  byte read from instruction memory at pc_in.
REQ-006 pc_in  input  8  fetch address of instr_in.
REQ-007 pc_plus_1_in  input  8  pc_in + 1 from fetch adder.
REQ-008 in_port  input  8  external input port sample.
REQ-009 instr_D  output  8  opcode byte to decode; 8'h00 = NOP.
REQ-010 imm_D  output  8  immediate byte of a two-byte instruction; 8'h00 otherwise.
REQ-011 pc_D  output  8  address of the opcode byte.
REQ-012 pc_plus_1_D  output  8  return/next address: opcode address + 1 for one-byte instructions, + 2 for two-byte instructions.
REQ-013 in_port_D  output  8  in_port registered alongside the instruction.
REQ-014 valid_D  output  1  1 = instr_D/imm_D form a complete instruction; 0 = bubble.
REQ-015 fetch_imm  output  1  1 while the FSM is in S_IMM; the hazard unit uses it to suppress decode.

Function
REQ-016 The module SHALL classify an opcode as two-byte when instr_in[7:4] matches any entry of the package constant TWO_BYTE_OPS (LDM=4'hC, LDD=4'hD, STD=4'hE).
REQ-017 The FSM SHALL have states S_OP (expect opcode) and S_IMM (expect immediate).
REQ-018 S_OP, no stall/flush, one-byte opcode: next cycle instr_D=instr_in, imm_D=0, pc_D=pc_in, pc_plus_1_D=pc_plus_1_in, in_port_D=in_port, valid_D=1; stay in S_OP.
REQ-019 S_OP, no stall/flush, two-byte opcode: next cycle latch instr_D, pc_D and in_port_D as in REQ-018; valid_D=0, imm_D=0; go to S_IMM.
REQ-020 S_IMM, no stall/flush: next cycle imm_D=instr_in, pc_plus_1_D=pc_plus_1_in (opcode address + 2); hold instr_D, pc_D and in_port_D; valid_D=1; go to S_OP.
REQ-021 A complete two-byte instruction SHALL appear on the outputs exactly 2 cycles after its opcode byte is presented; a one-byte instruction 1 cycle after.
REQ-022 stall_D=1 with flush_D=0 SHALL hold the state register and every output unchanged, in either state.
REQ-023 flush_D=1 SHALL take priority over stall_D: on the next edge all data outputs go to 0, valid_D=0, state goes to S_OP.
REQ-024 A flush in S_IMM SHALL abandon the partial instruction; the next byte is treated as an opcode.
REQ-025 fetch_imm SHALL be a registered decode of the state (1 iff S_IMM), with no combinational path from inputs.
REQ-026 PC arithmetic SHALL wrap modulo 256; opcode at 8'hFF takes its immediate from 8'h00 and pc_plus_1_D is 8'h01. The wrap is performed upstream and is passed through unchanged.

Reset
REQ-027 reset=0 SHALL immediately force state=S_OP and instr_D, imm_D, pc_D, pc_plus_1_D, in_port_D=8'h00, valid_D=0, fetch_imm=0, regardless of clk.
REQ-028 Reset asserted while in S_IMM SHALL drop the partial instruction. After release, the first sampled byte is an opcode.
REQ-029 The first rising edge after reset release SHALL behave as a normal S_OP cycle.

Structure
REQ-030 The state encoding (S_OP=1'b0, S_IMM=1'b1) and the TWO_BYTE_OPS opcode constants SHALL reside in the shared processor package, which the decoder also uses.
REQ-031 The two-byte classifier SHALL be a separate combinational sub-module, opcode_len_decode (input opcode[3:0], output is_two_byte), reusable by the hazard unit.
REQ-032 No other sub-modules; a single sequential process holds the state and output registers.

Verification
REQ-033 Reset mid-S_IMM: opcode 8'hC1 at pc 8'h10, then reset low for half a cycle -> all outputs 0, fetch_imm=0; next byte 8'h20 decoded as a one-byte instruction.
REQ-034 One-byte stream: 8'h20 @pc 8'h05 -> next cycle instr_D=8'h20, pc_D=8'h05, pc_plus_1_D=8'h06, valid_D=1, imm_D=0.
REQ-035 Two-byte: 8'hC1 @8'h10, then 8'h5A @8'h11 -> cycle 1: valid_D=0, fetch_imm=1; cycle 2: instr_D=8'hC1, imm_D=8'h5A, pc_D=8'h10, pc_plus_1_D=8'h12, valid_D=1.
REQ-036 Stall in S_IMM: 8'hD2, then stall_D=1 for 3 cycles, then 8'h33 -> outputs frozen with fetch_imm=1 during the stall; afterwards imm_D=8'h33, valid_D=1.
REQ-037 Flush priority: stall_D=1 and flush_D=1 together in S_IMM -> next cycle all outputs 0, valid_D=0, state S_OP.
REQ-038 Wrap: 8'hE0 @8'hFF, 8'h44 @8'h00 -> instr_D=8'hE0, imm_D=8'h44, pc_D=8'hFF, pc_plus_1_D=8'h01.
